// File: rtl/barrel_shift_unit.sv
// Multi-mode shift register: loads an operand, applies the requested shift in
// chunks of at most MAXSTEP positions per clock, then holds the result and pulses done.
module barrel_shift_unit #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAXSTEP = WIDTH - 1,
  localparam int unsigned AW     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] DataIn,
  input  logic [2:0]       mode,
  input  logic [AW-1:0]    AMT,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [2:0]    MODE_SLL = 3'b001;
  localparam logic [2:0]    MODE_SRL = 3'b010;
  localparam logic [2:0]    MODE_SRA = 3'b011;
  localparam logic [2:0]    MODE_ROL = 3'b100;
  localparam logic [2:0]    MODE_ROR = 3'b101;
  localparam logic [AW-1:0] STEP_MAX = AW'(MAXSTEP);

  state_t           state;
  state_t           state_next;
  logic [AW-1:0]    rem;
  logic [AW-1:0]    rem_next;
  logic [AW-1:0]    step;
  logic [2:0]       mode_q;
  logic [2:0]       mode_next;
  logic [WIDTH-1:0] r_next;

  // Modes 000 and 11x leave the operand untouched.
  function automatic logic is_pass(input logic [2:0] m);
    is_pass = (m == 3'b000) || (m[2:1] == 2'b11);
  endfunction

  // One partial shift of v by s positions; rotates use a doubled vector so the
  // bits leaving one end re-enter at the other.
  function automatic logic [WIDTH-1:0] shift_op(input logic [2:0]       m,
                                                input logic [WIDTH-1:0] v,
                                                input logic [AW-1:0]    s);
    logic [2*WIDTH-1:0] dbl;
    dbl      = {v, v};
    shift_op = v;
    case (m)
      MODE_SLL: shift_op = v << s;
      MODE_SRL: shift_op = v >> s;
      MODE_SRA: shift_op = WIDTH'($signed(v) >>> s);
      MODE_ROL: begin
        dbl      = dbl << s;
        shift_op = dbl[2*WIDTH-1:WIDTH];
      end
      MODE_ROR: begin
        dbl      = dbl >> s;
        shift_op = dbl[WIDTH-1:0];
      end
      default:  shift_op = v;
    endcase
  endfunction

  // Next-state and datapath decode.
  always_comb begin
    state_next = state;
    r_next     = R;
    rem_next   = rem;
    mode_next  = mode_q;
    step       = '0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (load) begin
          r_next     = DataIn;
          rem_next   = AMT;
          mode_next  = mode;
          state_next = ((AMT == '0) || is_pass(mode)) ? ST_DONE : ST_SHIFT;
        end else if (state == ST_DONE) begin
          state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        step     = (rem > STEP_MAX) ? STEP_MAX : rem;
        r_next   = shift_op(mode_q, R, step);
        rem_next = rem - step;
        if (rem_next == '0) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, datapath and status registers; busy/done track the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state  <= ST_IDLE;
      R      <= '0;
      rem    <= '0;
      mode_q <= 3'b000;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      R      <= r_next;
      rem    <= rem_next;
      mode_q <= mode_next;
      busy   <= (state_next == ST_SHIFT);
      done   <= (state_next == ST_DONE);
    end
  end

endmodule

// File: tb/tb_barrel_shift_unit.sv
// Bench for barrel_shift_unit: directed and random operations on a MAXSTEP=2 and
// a MAXSTEP=7 instance, checked against a single-shift reference and latency formula.
module tb_barrel_shift_unit;

  logic       clk = 1'b0;
  logic       clear;
  logic       load;
  logic [7:0] din;
  logic [2:0] mode;
  logic [2:0] amt;
  logic [7:0] r2, r7;
  logic       busy2, busy7, done2, done7;

  int checks   = 0;
  int failures = 0;
  logic [7:0] last_exp;

  always #5 clk = ~clk;

  barrel_shift_unit #(.WIDTH(8), .MAXSTEP(2)) dut2 (
    .clk(clk), .clear(clear), .load(load), .DataIn(din), .mode(mode), .AMT(amt),
    .R(r2), .busy(busy2), .done(done2)
  );

  barrel_shift_unit #(.WIDTH(8), .MAXSTEP(7)) dut7 (
    .clk(clk), .clear(clear), .load(load), .DataIn(din), .mode(mode), .AMT(amt),
    .R(r7), .busy(busy7), .done(done7)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result of one shift by the whole amount.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] m, input int a);
    case (m)
      3'b001:  ref_shift = 8'(d << a);
      3'b010:  ref_shift = 8'(d >> a);
      3'b011:  ref_shift = 8'($signed(d) >>> a);
      3'b100:  ref_shift = 8'((d << a) | (d >> (8 - a)));
      3'b101:  ref_shift = 8'((d >> a) | (d << (8 - a)));
      default: ref_shift = d;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] m, input int a, input int ms);
    if (a == 0 || m == 3'b000 || m[2:1] == 2'b11) ref_latency = 1;
    else ref_latency = 1 + (a + ms - 1) / ms;
  endfunction

  // Caller is at a negedge; drives a load, optionally injects a junk load while
  // busy at cycle 'inject', and returns at the negedge where done is observed.
  task automatic run_op(input int sel, input logic [7:0] d, input logic [2:0] m,
                        input int a, input int inject, input string tag);
    int   ms, lat, bcnt, cyc;
    logic seen, b, dn;
    logic [7:0] rr;
    ms   = (sel == 7) ? 7 : 2;
    lat  = ref_latency(m, a, ms);
    last_exp = ref_shift(d, m, a);
    din  = d;
    mode = m;
    amt  = 3'(a);
    load = 1'b1;
    bcnt = 0;
    cyc  = 0;
    seen = 1'b0;
    rr   = '0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (cyc == 1) load = 1'b0;
      if (inject > 1 && cyc == inject) begin
        load = 1'b1;
        din  = ~d;
        mode = 3'b001;
        amt  = 3'd1;
      end else if (inject > 1 && cyc == inject + 1) begin
        load = 1'b0;
      end
      b  = (sel == 7) ? busy7 : busy2;
      dn = (sel == 7) ? done7 : done2;
      rr = (sel == 7) ? r7 : r2;
      if (b) bcnt++;
      if (dn) seen = 1'b1;
    end
    chk($sformatf("%s/done_seen", tag), 32'(seen), 32'd1);
    chk($sformatf("%s/latency", tag), 32'(cyc), 32'(lat));
    chk($sformatf("%s/busy_cycles", tag), 32'(bcnt), 32'(lat - 1));
    chk($sformatf("%s/R", tag), 32'(rr), 32'(last_exp));
  endtask

  // One idle clock after done: pulse has ended and R is held.
  task automatic post_check(input int sel, input string tag);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("%s/done_pulse", tag), 32'((sel == 7) ? done7 : done2), 32'd0);
    chk($sformatf("%s/idle_busy", tag), 32'((sel == 7) ? busy7 : busy2), 32'd0);
    chk($sformatf("%s/R_hold", tag), 32'((sel == 7) ? r7 : r2), 32'(last_exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    clear = 1'b1;
    load  = 1'b0;
    din   = 8'h00;
    mode  = 3'b000;
    amt   = 3'd0;
    @(negedge clk);
    chk("reset/R", 32'(r2), 32'd0);
    chk("reset/busy", 32'(busy2), 32'd0);
    chk("reset/done", 32'(done2), 32'd0);
    chk("reset/R7", 32'(r7), 32'd0);
    clear = 1'b0;
    @(negedge clk);

    run_op(2, 8'hB4, 3'b001, 3, 0, "sll_b4");      post_check(2, "sll_b4");
    chk("sll_b4/literal", 32'(r2), 32'hA0);
    run_op(2, 8'h96, 3'b011, 5, 0, "sra_96");      post_check(2, "sra_96");
    chk("sra_96/literal", 32'(r2), 32'hFC);
    run_op(2, 8'h81, 3'b101, 7, 0, "ror_81");      post_check(2, "ror_81");
    chk("ror_81/literal", 32'(r2), 32'h03);
    run_op(2, 8'h81, 3'b100, 7, 0, "rol_81");      post_check(2, "rol_81");
    chk("rol_81/literal", 32'(r2), 32'hC0);
    run_op(2, 8'h5A, 3'b010, 0, 0, "zero_amt");    post_check(2, "zero_amt");
    run_op(2, 8'h3C, 3'b000, 6, 0, "pass_000");    post_check(2, "pass_000");
    run_op(2, 8'hC3, 3'b111, 4, 0, "pass_111");    post_check(2, "pass_111");
    run_op(2, 8'hFF, 3'b010, 6, 2, "ignore_load"); post_check(2, "ignore_load");
    chk("ignore_load/literal", 32'(r2), 32'h03);

    for (int i = 0; i < 24; i++) begin
      run_op(2, 8'($urandom), 3'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 0, "rnd2");
      post_check(2, "rnd2");
    end

    // Back-to-back on the slow instance: load accepted in the done cycle.
    run_op(2, 8'h0F, 3'b100, 5, 0, "b2b2_a");
    run_op(2, 8'hE1, 3'b011, 3, 0, "b2b2_b");
    post_check(2, "b2b2_b");

    // Abort mid-shift with clear.
    din = 8'hFF; mode = 3'b010; amt = 3'd6; load = 1'b1;
    @(posedge clk); @(negedge clk);
    load = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("abort/busy_before", 32'(busy2), 32'd1);
    clear = 1'b1;
    #1;
    chk("abort/R", 32'(r2), 32'd0);
    chk("abort/busy", 32'(busy2), 32'd0);
    chk("abort/done", 32'(done2), 32'd0);
    @(posedge clk); @(negedge clk);
    clear = 1'b0;
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      if (done2 || busy2) dcount++;
    end
    chk("abort/no_done", 32'(dcount), 32'd0);
    chk("abort/R_after", 32'(r2), 32'd0);

    // MAXSTEP=7: every amount finishes in one shift clock, chained back-to-back.
    for (int a = 1; a < 8; a++) begin
      run_op(7, 8'($urandom), 3'($urandom_range(1, 5)), a, 0, "ms7_amt");
    end
    for (int i = 0; i < 24; i++) begin
      run_op(7, 8'($urandom), 3'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 0, "ms7_rnd");
    end
    post_check(7, "ms7_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
